// File: rtl/updown_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
package updown_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A divide-by-one prescaler still needs a one-bit register to stay legal.
  function automatic int unsigned pre_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/updown_counter_prm_tick_prescaler.sv
// Free-running divide-by-TICK_DIV prescaler; tick is the combinational step strobe.
module tick_prescaler
  import updown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     PW       = pre_width(TICK_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick = en && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr || tick) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/updown_counter_prm.sv
// Up/down event counter with prescaler, programmable terminal value and wrap/saturate modes.
module updown_counter_prm
  import updown_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     TICK_DIV = 10_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);

  logic             step_int;
  mode_e            mode;
  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             tc_q, tc_d;

  assign mode = mode_e'(sat);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .tick  (step_int)
  );

  // Load beats a coincident step; terminal steps either wrap or hold at the end.
  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_L) ? MAX_L : load_val;
    end else if (step_int) begin
      step_d = 1'b1;
      if (dir == DIR_UP) begin
        if (count_q == MAX_L) begin
          tc_d    = 1'b1;
          count_d = (mode == MODE_SAT) ? MAX_L : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          count_d = (mode == MODE_SAT) ? '0 : MAX_L;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      step_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_updown_counter_prm.sv
// Directed scoreboard bench for updown_counter_prm with WIDTH=8, MAX_VAL=9, TICK_DIV=4.
module tb_updown_counter_prm;

  localparam int MAXV = 9;
  localparam int DIV  = 4;

  typedef struct {
    int   cnt;
    logic step;
    logic tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [7:0] count;
  logic       step;
  logic       tc;

  int   n_checks = 0;
  int   n_pass = 0;
  int   n_steps = 0;
  int   n_tcs = 0;
  int   steps_before;
  exp_t exp_q[$];

  int   m_cnt = 0;
  int   m_pre = 0;
  logic m_step = 1'b0;
  logic m_tc = 1'b0;

  updown_counter_prm #(
    .WIDTH    (8),
    .MAX_VAL  (MAXV),
    .TICK_DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .step     (step),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Reference behaviour for one clock edge, computed from the inputs now applied.
  task automatic model_next();
    logic si;
    si = en && (m_pre == DIV - 1);
    if (load) begin
      m_cnt  = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_pre  = 0;
      m_step = 1'b0;
      m_tc   = 1'b0;
    end else begin
      m_step = si;
      m_tc   = 1'b0;
      if (en) m_pre = si ? 0 : m_pre + 1;
      if (si) begin
        if (dir) begin
          if (m_cnt == MAXV) begin
            m_tc  = 1'b1;
            m_cnt = sat ? MAXV : 0;
          end else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin
            m_tc  = 1'b1;
            m_cnt = sat ? 0 : MAXV;
          end else m_cnt = m_cnt - 1;
        end
      end
    end
    exp_q.push_back('{cnt: m_cnt, step: m_step, tc: m_tc});
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_pre  = 0;
    m_step = 1'b0;
    m_tc   = 1'b0;
  endtask

  task automatic tick();
    exp_t e;
    model_next();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_count", {24'd0, count}, e.cnt);
    check("sb_step", {31'd0, step}, {31'd0, e.step});
    check("sb_tc", {31'd0, tc}, {31'd0, e.tc});
    if (step) n_steps++;
    if (tc) n_tcs++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_count", {24'd0, count}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", {24'd0, count}, 0);
    check("reset_step", {31'd0, step}, 0);
    check("reset_tc", {31'd0, tc}, 0);
    model_reset();
    rst_n = 1'b1;
    en = 1'b1; dir = 1'b1; sat = 1'b0;

    run(44);
    check("up44_count", {24'd0, count}, 1);
    check("up44_steps", n_steps, 11);
    check("up44_tcs", n_tcs, 1);

    dir = 1'b0;
    run(4);
    check("down_to_zero", {24'd0, count}, 0);
    run(4);
    check("down_wrap_count", {24'd0, count}, 9);
    check("down_wrap_tc", {31'd0, tc}, 1);
    run(4);
    check("down_after_wrap_count", {24'd0, count}, 8);
    check("down_after_wrap_tc", {31'd0, tc}, 0);

    sat = 1'b1; dir = 1'b1;
    run(4);
    check("sat_reach_max", {24'd0, count}, 9);
    check("sat_reach_tc", {31'd0, tc}, 0);
    run(4);
    check("sat_hold_count", {24'd0, count}, 9);
    check("sat_hold_tc", {31'd0, tc}, 1);
    check("sat_hold_step", {31'd0, step}, 1);
    run(4);
    check("sat_hold_again", {24'd0, count}, 9);
    dir = 1'b0;
    run(4);
    check("sat_down", {24'd0, count}, 8);

    run(1);
    load = 1'b1; load_val = 8'd200;
    tick();
    load = 1'b0;
    check("load_clamp", {24'd0, count}, 9);
    check("load_no_step", {31'd0, step}, 0);
    check("load_no_tc", {31'd0, tc}, 0);
    steps_before = n_steps;
    run(3);
    check("load_no_early_step", n_steps - steps_before, 0);
    tick();
    check("load_step_after4", {31'd0, step}, 1);
    check("load_step_count", {24'd0, count}, 8);
    run(3);
    load = 1'b1; load_val = 8'd3;
    tick();
    load = 1'b0;
    check("load_wins_count", {24'd0, count}, 3);
    check("load_wins_step", {31'd0, step}, 0);
    check("load_wins_tc", {31'd0, tc}, 0);

    run(2);
    en = 1'b0;
    run(10);
    check("en_frozen_count", {24'd0, count}, 3);
    en = 1'b1;
    tick();
    check("en_resume_wait", {31'd0, step}, 0);
    tick();
    check("en_resume_step", {31'd0, step}, 1);
    check("en_resume_count", {24'd0, count}, 2);

    load = 1'b1; load_val = 8'd5;
    tick();
    load = 1'b0;
    tick();
    check("pre_reset_count", {24'd0, count}, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", {24'd0, count}, 0);
    check("async_rst_step", {31'd0, step}, 0);
    check("async_rst_tc", {31'd0, tc}, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_held_count", {24'd0, count}, 0);
    rst_n = 1'b1;
    dir = 1'b1; sat = 1'b0;
    steps_before = n_steps;
    run(3);
    check("rst_release_no_early", n_steps - steps_before, 0);
    tick();
    check("rst_release_step", {31'd0, step}, 1);
    check("rst_release_count", {24'd0, count}, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
